// File: rtl/branch_target_buffer.sv
// branch_target_buffer
//   Direct-mapped BTB with 2-bit saturating direction counters.
//   Fetch side : fetch_pc -> pred_taken / pred_target / pred_index (combinational).
//   Mem side   : upd_* (resolved branch) trains the table on posedge CLK and
//                drives mispredict / correct_pc combinationally.
//   Stats      : hit_count (lookup hits per cycle), miss_count (mispredicts).
//   Reset      : nRST, asynchronous active-low.

// One table entry: valid, tag, target, 2-bit direction counter.
module btb_entry #(
  parameter int TAG_W  = 28,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_taken,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [WORD_W-1:0] wr_target,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [WORD_W-1:0] target,
  output logic [1:0]        cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
      cnt    <= 2'b01;
    end else if (wr_en) begin
      if (valid && tag == wr_tag) begin
        if (wr_taken) begin
          target <= wr_target;
          if (cnt != 2'b11) cnt <= cnt + 2'd1;
        end else if (cnt != 2'b00) begin
          cnt <= cnt - 2'd1;
        end
      end else if (wr_taken) begin
        // Allocate/replace; a not-taken miss leaves the entry alone.
        valid  <= 1'b1;
        tag    <= wr_tag;
        target <= wr_target;
        cnt    <= 2'b10;
      end
    end
  end
endmodule

module branch_target_buffer #(
  parameter int IDX_W  = 2,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] fetch_pc,
  output logic              pred_taken,
  output logic [WORD_W-1:0] pred_target,
  output logic [IDX_W-1:0]  pred_index,
  input  logic              upd_valid,
  input  logic [WORD_W-1:0] upd_pc,
  input  logic [IDX_W-1:0]  upd_index,
  input  logic              upd_taken,
  input  logic [WORD_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [WORD_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [WORD_W-1:0] correct_pc,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = WORD_W - IDX_W - 2;

  logic [ENTRIES-1:0]             valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
  logic [ENTRIES-1:0][WORD_W-1:0] tgt_q;
  logic [ENTRIES-1:0][1:0]        cnt_q;

  // Write address is the pipe-carried index, not upd_pc's index bits; only
  // the tag comes from upd_pc.
  genvar g;
  generate
    for (g = 0; g < ENTRIES; g++) begin : g_entry
      btb_entry #(.TAG_W(TAG_W), .WORD_W(WORD_W)) u_entry (
        .clk       (CLK),
        .rst_n     (nRST),
        .wr_en     (upd_valid && upd_index == IDX_W'(g)),
        .wr_taken  (upd_taken),
        .wr_tag    (upd_pc[WORD_W-1:IDX_W+2]),
        .wr_target (upd_target),
        .valid     (valid_q[g]),
        .tag       (tag_q[g]),
        .target    (tgt_q[g]),
        .cnt       (cnt_q[g])
      );
    end
  endgenerate

  // Lookup sees registered contents, so a same-cycle update shows next cycle.
  logic hit;
  assign pred_index  = fetch_pc[IDX_W+1:2];
  assign hit         = valid_q[pred_index] &&
                       tag_q[pred_index] == fetch_pc[WORD_W-1:IDX_W+2];
  assign pred_taken  = hit && cnt_q[pred_index][1];
  assign pred_target = hit ? tgt_q[pred_index] : '0;

  logic unused_fetch_lsb;
  assign unused_fetch_lsb = ^fetch_pc[1:0];

  // Target only matters when the branch was actually taken.
  assign mispredict = nRST && upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && upd_target != upd_pred_target));
  assign correct_pc = upd_taken ? upd_target : upd_pc + WORD_W'(4);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)        hit_count  <= hit_count + 32'd1;
      if (mispredict) miss_count <= miss_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;
  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pred_index;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_index;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  branch_target_buffer #(.IDX_W(2), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_index(pred_index),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_index(upd_index),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .correct_pc(correct_pc),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table as plain arrays, counter as an integer 0..3.
  bit          m_valid[4];
  int unsigned m_tag[4];
  logic [31:0] m_tgt[4];
  int          m_cnt[4];
  logic [31:0] m_hits, m_miss;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
    m_hits = 0; m_miss = 0;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int i = int'((pc >> 2) % 4);
    return m_valid[i] && m_tag[i] == (pc >> 4);
  endfunction

  typedef struct {
    logic [31:0] fpc;
    logic        uv;
    logic [31:0] upc;
    logic [1:0]  uidx;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        e_pt;
    logic [31:0] e_tgt;
    logic        e_mis;
    logic [31:0] e_cpc;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                              input logic [1:0] uidx, input logic ut, input logic [31:0] utgt,
                              input logic upt, input logic [31:0] uptgt, input logic e_pt,
                              input logic [31:0] e_tgt, input logic e_mis, input logic [31:0] e_cpc);
    vec_t v;
    v.fpc = fpc; v.uv = uv; v.upc = upc; v.uidx = uidx; v.ut = ut; v.utgt = utgt;
    v.upt = upt; v.uptgt = uptgt; v.e_pt = e_pt; v.e_tgt = e_tgt; v.e_mis = e_mis; v.e_cpc = e_cpc;
    return v;
  endfunction

  function automatic vec_t idle(input logic [31:0] fpc, input logic e_pt, input logic [31:0] e_tgt);
    return mk(fpc, 0, 0, 0, 0, 0, 0, 0, e_pt, e_tgt, 0, 32'h4);
  endfunction

  // Entered just after a posedge; leaves just after the next one.
  task automatic run_cycle(input vec_t v, input bit use_exp);
    bit          h, m_pt, m_mis;
    logic [31:0] m_tg, m_cpc;
    int          i;
    fetch_pc = v.fpc; upd_valid = v.uv; upd_pc = v.upc; upd_index = v.uidx;
    upd_taken = v.ut; upd_target = v.utgt; upd_pred_taken = v.upt; upd_pred_target = v.uptgt;
    @(negedge CLK);
    h     = model_hit(v.fpc);
    i     = int'((v.fpc >> 2) % 4);
    m_pt  = h && m_cnt[i] >= 2;
    m_tg  = h ? m_tgt[i] : 32'h0;
    m_mis = v.uv && ((v.ut != v.upt) || (v.ut && v.utgt != v.uptgt));
    m_cpc = v.ut ? v.utgt : v.upc + 32'd4;
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_pt});
    chk("pred_target", pred_target, m_tg);
    chk("pred_index", {30'd0, pred_index}, (v.fpc >> 2) % 4);
    chk("mispredict", {31'd0, mispredict}, {31'd0, m_mis});
    chk("correct_pc", correct_pc, m_cpc);
    if (use_exp) begin
      chk("vec_pred_taken", {31'd0, pred_taken}, {31'd0, v.e_pt});
      chk("vec_pred_target", pred_target, v.e_tgt);
      chk("vec_mispredict", {31'd0, mispredict}, {31'd0, v.e_mis});
      chk("vec_correct_pc", correct_pc, v.e_cpc);
    end
    @(posedge CLK);
    if (h) m_hits++;
    if (m_mis) m_miss++;
    if (v.uv) begin
      i = int'(v.uidx);
      if (m_valid[i] && m_tag[i] == (v.upc >> 4)) begin
        if (v.ut) begin
          m_tgt[i] = v.utgt;
          m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (v.ut) begin
        m_valid[i] = 1; m_tag[i] = v.upc >> 4; m_tgt[i] = v.utgt; m_cnt[i] = 2;
      end
    end
    #1;
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_miss);
  endtask

  vec_t tbl[$];

  initial begin
    // Directed sequence; expectations worked out by hand.
    tbl.push_back(mk(32'h10, 1, 32'h10, 0, 1, 32'h100, 0, 0,      0, 0, 1, 32'h100)); // cold miss
    tbl.push_back(idle(32'h10, 1, 32'h100));
    tbl.push_back(mk(32'h10, 1, 32'h10, 0, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h100)); // 2->3
    tbl.push_back(mk(32'h10, 1, 32'h10, 0, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h100)); // held
    tbl.push_back(mk(32'h10, 1, 32'h10, 0, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h100)); // held
    tbl.push_back(mk(32'h10, 1, 32'h10, 0, 0, 0, 1, 32'h100,      1, 32'h100, 1, 32'h14)); // 3->2
    tbl.push_back(mk(32'h10, 1, 32'h10, 0, 0, 0, 1, 32'h100,      1, 32'h100, 1, 32'h14)); // 2->1
    tbl.push_back(idle(32'h10, 0, 32'h100));               // hit, weakly not-taken
    tbl.push_back(idle(32'h110, 0, 0));                    // alias misses
    tbl.push_back(mk(32'h110, 1, 32'h110, 0, 1, 32'h200, 0, 0,    0, 0, 1, 32'h200)); // replace
    tbl.push_back(idle(32'h10, 0, 0));                     // old pc misses
    tbl.push_back(idle(32'h110, 1, 32'h200));
    tbl.push_back(mk(32'h110, 1, 32'h20, 0, 0, 0, 1, 32'h300,     1, 32'h200, 1, 32'h24)); // NT mispredict
    tbl.push_back(mk(32'h110, 1, 32'h20, 0, 0, 0, 0, 0,           1, 32'h200, 0, 32'h24)); // correct NT
    tbl.push_back(mk(32'h14, 1, 32'h14, 1, 1, 32'h400, 0, 0,      0, 0, 1, 32'h400)); // same-cycle r/w
    tbl.push_back(idle(32'h14, 1, 32'h400));
    tbl.push_back(mk(32'h1C, 1, 32'h18, 3, 1, 32'h500, 0, 0,      0, 0, 1, 32'h500)); // corrupted idx
    tbl.push_back(idle(32'h1C, 1, 32'h500));
    tbl.push_back(idle(32'h18, 0, 0));
    tbl.push_back(mk(32'h1C, 1, 32'hFFFFFFFC, 3, 0, 0, 0, 0,      1, 32'h500, 0, 32'h0)); // pc+4 wraps
    tbl.push_back(mk(32'h1C, 1, 32'h1C, 3, 1, 32'h600, 1, 32'h500, 1, 32'h500, 1, 32'h600)); // tgt miss
    tbl.push_back(idle(32'h1C, 1, 32'h600));

    // Reset state
    nRST = 0; fetch_pc = 32'h40; upd_valid = 1; upd_pc = 32'h20; upd_index = 0;
    upd_taken = 0; upd_target = 0; upd_pred_taken = 1; upd_pred_target = 0;
    model_reset();
    #3;
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_target", pred_target, 32'd0);
    chk("rst_pred_index", {30'd0, pred_index}, 32'd0);
    chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst_correct_pc", correct_pc, 32'h24);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    upd_valid = 0;
    @(negedge CLK); @(negedge CLK);
    nRST = 1;
    @(posedge CLK); #1;

    foreach (tbl[k]) run_cycle(tbl[k], 1'b1);

    // Reset mid-operation with a pending update in the same cycle.
    fetch_pc = 32'h14; upd_valid = 1; upd_pc = 32'h24; upd_index = 1;
    upd_taken = 1; upd_target = 32'h700; upd_pred_taken = 0; upd_pred_target = 0;
    #2 nRST = 0;
    #1;
    chk("midrst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("midrst_pred_target", pred_target, 32'd0);
    chk("midrst_pred_index", {30'd0, pred_index}, 32'd1);
    chk("midrst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("midrst_hit_count", hit_count, 32'd0);
    chk("midrst_miss_count", miss_count, 32'd0);
    @(posedge CLK); #1;
    model_reset();
    upd_valid = 0;
    nRST = 1;
    run_cycle(idle(32'h24, 0, 0), 1'b1);   // dropped update
    run_cycle(idle(32'h14, 0, 0), 1'b1);   // table cleared

    // Random phase against the model.
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      logic [31:0] tgts [4];
      tgts[0] = 32'h100; tgts[1] = 32'h204; tgts[2] = 32'h3F8; tgts[3] = 32'h1000;
      v.fpc  = {26'($urandom_range(0, 3)), 2'($urandom), 4'($urandom) & 4'hC};
      v.uv   = ($urandom_range(0, 3) != 0);
      v.upc  = ($urandom_range(0, 30) == 0) ? 32'hFFFFFFFC
               : {26'($urandom_range(0, 3)), 2'($urandom), 4'($urandom) & 4'hC};
      v.uidx = ($urandom_range(0, 9) == 0) ? 2'($urandom) : v.upc[3:2];
      v.ut   = 1'($urandom);
      v.utgt = tgts[$urandom_range(0, 3)];
      v.upt  = 1'($urandom);
      v.uptgt = ($urandom_range(0, 2) == 0) ? tgts[$urandom_range(0, 3)] : v.utgt;
      v.e_pt = 0; v.e_tgt = 0; v.e_mis = 0; v.e_cpc = 0;
      run_cycle(v, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Fetch side: looks up the current fetch PC and drives btb_taken / btb_target / btb_index into the fetch latch.
- Memory-stage side: consumes the resolved branch fields (beq/bne, brTake, brTarget, btb_*) and trains the table.
- Reports mispredictions and the corrected PC to the hazard/PC-select logic.

Parameters:
- IDX_W, 2, index width; ENTRIES = 2**IDX_W; matches the 2-bit btb_index pipeline field.
- WORD_W, 32, PC/target width (word_t).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- fetch_pc  in  WORD_W  PC being fetched this cycle.
- pred_taken  out  1  predict taken (to ifetch btb_taken).
- pred_target  out  WORD_W  predicted target (to ifetch btb_target).
- pred_index  out  IDX_W  entry used for the lookup (to ifetch btb_index).
- upd_valid  in  1  memory-stage instruction is beq or bne and the stage is advancing.
- upd_pc  in  WORD_W  PC of the resolved branch.
- upd_index  in  IDX_W  btb_index carried down the pipe.
- upd_taken  in  1  resolved outcome (brTake).
- upd_target  in  WORD_W  resolved branch target (brTarget).
- upd_pred_taken  in  1  btb_taken carried down the pipe.
- upd_pred_target  in  WORD_W  btb_target carried down the pipe.
- mispredict  out  1  branch resolved against the prediction; flush and redirect.
- correct_pc  out  WORD_W  redirect PC when mispredict=1.
- hit_count  out  32  lookups that hit a valid, tag-matching entry.
- miss_count  out  32  resolved branches with mispredict=1.

Behaviour:
- Entry fields: valid bit, tag = pc[WORD_W-1:IDX_W+2], target word, 2-bit counter. Index = pc[IDX_W+1:2].
- Reset (nRST=0, async): all valid=0, counters=2'b01, targets=0, tags=0, hit_count=0, miss_count=0.
- Outputs during reset: pred_taken=0, pred_target=0, mispredict=0.
- pred_index = fetch_pc[IDX_W+1:2], even during reset.
- correct_pc during reset follows the rule below (upd_pc+4 when upd_taken=0).
- Lookup is combinational, zero latency.
  - hit = valid & tag match.
  - pred_taken = hit & cnt[1].
  - pred_target = stored target when hit, else 0.
- Mispredict is combinational from the upd_* inputs:
  - mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)).
  - correct_pc = upd_taken ? upd_target : upd_pc + 4, mod 2^32 wrap.
- Training is on posedge CLK when upd_valid=1, to entry upd_index, with tag compared against upd_pc:
  - Tag hit: counter +1 if taken, saturating at 2'b11; -1 if not taken, saturating at 2'b00. Target overwritten with upd_target when taken.
  - Tag miss, taken: allocate/replace the entry. valid=1, new tag, target=upd_target, counter=2'b10 (weakly taken).
  - Tag miss, not taken: no change.
- Counters update on posedge CLK:
  - hit_count +1 per cycle in which hit=1.
  - miss_count +1 when mispredict=1.
  - Both wrap at 2^32.
- Same-cycle lookup and update of one entry: the lookup sees the pre-update contents; the new state is visible the next cycle.
- Update with upd_index != upd_pc[IDX_W+1:2] (corrupted pipe field): upd_index wins as the write address.
- Reset asserted mid-operation clears the table immediately; a pending update in that cycle is dropped.

Test Plan:
- Reset with fetch_pc=0x00000040 -> pred_taken=0, pred_target=0, pred_index=0, hit_count=0, miss_count=0.
- Cold miss: update pc=0x00000010, idx=0, taken=1, target=0x00000100, pred_taken=0 -> mispredict=1, correct_pc=0x00000100. Next cycle lookup of 0x00000010 -> pred_taken=1, pred_target=0x00000100, miss_count=1.
- Saturation:
  - From the counter at 2'b10, three taken updates -> counter 2'b11 and held.
  - Then two not-taken updates -> 2'b01; lookup gives pred_taken=0 while still a hit, and hit_count increments.
- Alias: an entry holds pc 0x00000010; lookup of 0x00000110 (same index, different tag) -> pred_taken=0. A taken update of 0x00000110 replaces the entry; the old PC then misses.
- Not-taken mispredict: pred_taken=1, upd_taken=0, upd_pc=0x00000020 -> mispredict=1, correct_pc=0x00000024. Correct not-taken prediction -> mispredict=0.
- Same-cycle read/write: update idx 1 while fetch_pc maps to idx 1 -> old prediction this cycle, new prediction next cycle. Assert nRST in the same cycle -> table cleared, update lost.
